// File: rtl/sram_scan_reader_if.sv
// sram_scan_reader_if
//   Bundles the reader's two buses: the SRAM read port and the valid/ready
//   output stream.
//   Signals:
//     o_sram_addr  [ADDR_WIDTH] read address to SRAM (reader drives)
//     o_sram_write [1]          SRAM write enable, held 0 (reader drives)
//     i_sram_data  [DATA_WIDTH] SRAM registered read data (SRAM drives)
//     o_data       [DATA_WIDTH] head-of-buffer word (reader drives)
//     o_valid      [1]          o_data is valid (reader drives)
//     i_ready      [1]          sink accepts o_data (sink drives)
//   Modports: master = reader side, slave = SRAM/sink side.
interface sram_scan_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] o_sram_addr;
    logic                  o_sram_write;
    logic [DATA_WIDTH-1:0] i_sram_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output o_sram_addr, o_sram_write, o_data, o_valid,
        input  i_sram_data, i_ready
    );

    modport slave (
        input  o_sram_addr, o_sram_write, o_data, o_valid,
        output i_sram_data, i_ready
    );
endinterface

// File: rtl/sram_scan_reader.sv
// sram_scan_reader
//   Walks SRAM addresses 0..DEPTH-1 after a start pulse, absorbs the SRAM's
//   one-cycle registered read latency and streams the words in address order
//   through a 2-entry valid/ready output buffer (1 word/clock when the sink
//   is always ready).
//   Ports:
//     i_clk, i_rst  clock (rising edge), asynchronous active-high reset
//     i_start       begin a frame (sampled only in IDLE)
//     i_stop        end continuous scanning (SCAN_REPEAT_EN builds only)
//     o_busy        high while RUN or DRAIN
//     o_done        one-cycle pulse after the last word of a frame is accepted
//     bus           sram_scan_reader_if.master: SRAM read port + output stream
//   Build option: define SCAN_REPEAT_EN for continuous frame scanning that
//   ends on i_stop; undefined gives single-frame operation.
module sram_scan_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_stop,
    output logic                    o_busy,
    output logic                    o_done,
    sram_scan_reader_if.master      bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] out_idx;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count;
    logic                  pop, issue, end_scan;
    logic [2:0]            occ;

`ifdef SCAN_REPEAT_EN
    logic stop_q;
    // An i_stop arriving in the cycle that issues DEPTH-1 still ends this frame.
    assign end_scan = stop_q | i_stop;
`else
    logic unused_stop;
    assign unused_stop = i_stop;
    assign end_scan    = 1'b1;
`endif

    assign pop              = (count != 2'd0) && bus.i_ready;
    assign occ              = {1'b0, count} + {2'b00, inflight};
    assign o_busy           = (state != IDLE);
    assign bus.o_sram_addr  = addr;
    assign bus.o_sram_write = 1'b0;
    assign bus.o_data       = fifo_q[rd_ptr];
    assign bus.o_valid      = (count != 2'd0);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = RUN;
            end
            RUN: begin
                // count + inflight - pop < 2, kept non-negative.
                issue = (occ < (3'd2 + {2'b00, pop}));
                if (issue && (addr == LAST) && end_scan) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!inflight && ((count == 2'd0) || (count == 2'd1 && pop)))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            addr     <= '0;
            out_idx  <= '0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
            o_done   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            o_done   <= pop && (out_idx == LAST);
            count    <= count + {1'b0, inflight} - {1'b0, pop};
            if (issue) addr <= (addr == LAST) ? '0 : addr + 1'b1;
            if (inflight) begin
                fifo_q[wr_ptr] <= bus.i_sram_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_idx <= (out_idx == LAST) ? '0 : out_idx + 1'b1;
            end
        end
    end

`ifdef SCAN_REPEAT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                     stop_q <= 1'b0;
        else if (state == IDLE)        stop_q <= 1'b0;
        else if (state == RUN && i_stop) stop_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sram_scan_reader.sv
// tb_sram_scan_reader
//   Randomised bench for sram_scan_reader: an SRAM array model feeds the DUT,
//   and the expected stream is simply mem[k mod DEPTH] for the k-th accepted
//   word, with o_done expected right after each frame's last word.
module tb_sram_scan_reader;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic i_clk = 1'b0;
    logic i_rst, i_start, i_stop, o_busy, o_done;

    sram_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_stop  (i_stop),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [DW-1:0] mem [DEPTH];

    // SRAM: registered read whenever write is low.
    always @(posedge i_clk) if (!bus.o_sram_write) bus.i_sram_data <= mem[bus.o_sram_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Sink ready pattern: 0 always ready, 1 random 50%, 2 held low.
    int rdy_mode = 0;
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = 1'($urandom_range(0, 1));
                default: bus.i_ready = 1'b0;
            endcase
        end
    end

    // Reference model state.
    bit            mon_en    = 1'b0;
    int            n_pop     = 0;
    int            n_done    = 0;
    bit            done_pend = 1'b0;
    bit            hold_pend = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge i_clk) begin
        if (mon_en) begin
            check("sram_write", bus.o_sram_write, 0);
            check("done", o_done, done_pend);
            if (o_done) begin
                n_done++;
`ifndef SCAN_REPEAT_EN
                check("busy_after_done", o_busy, 0);
`endif
            end
            if (hold_pend) begin
                check("hold_valid", bus.o_valid, 1);
                check("hold_data", bus.o_data, prev_data);
            end
            done_pend = 1'b0;
            if (bus.o_valid && bus.i_ready) begin
                check("data", bus.o_data, mem[n_pop % DEPTH]);
                done_pend = ((n_pop % DEPTH) == DEPTH - 1);
                n_pop++;
            end
            hold_pend = bus.o_valid && !bus.i_ready;
            prev_data = bus.o_data;
        end
    end

    task automatic clear_model();
        n_pop     = 0;
        n_done    = 0;
        done_pend = 1'b0;
        hold_pend = 1'b0;
    endtask

    task automatic fill_mem(input bit ramp);
        for (int a = 0; a < DEPTH; a++) mem[a] = ramp ? DW'(a) : DW'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_done"},  o_done, 0);
        check({tag, "_addr"},  bus.o_sram_addr, 0);
        check({tag, "_write"}, bus.o_sram_write, 0);
        check({tag, "_data"},  bus.o_data, 0);
        check({tag, "_valid"}, bus.o_valid, 0);
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        while (o_busy && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
        end
        check("idle_reached", o_busy, 0);
        @(negedge i_clk);
    endtask

    task automatic wait_pops(input int n, input int budget);
        int cyc = 0;
        while (n_pop < n && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
        end
        check("word_reached", 32'(n_pop >= n), 1);
    endtask

    initial begin
        int cyc;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        fill_mem(1'b1);
        #3;
        check_reset_outputs("reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        clear_model();
        mon_en = 1'b1;

        // Ramp data, always ready: latency, full-rate frame.
        rdy_mode = 0;
        pulse_start();
        @(negedge i_clk);
        check("lat_e0", bus.o_valid, 0);
        @(negedge i_clk);
        check("lat_e1", bus.o_valid, 0);
        @(negedge i_clk);
        check("lat_e2", bus.o_valid, 1);
        cyc = 2;
        while (!o_done && cyc < 4 * DEPTH) begin
            @(negedge i_clk);
            cyc++;
        end
        check("frame_clocks", cyc, DEPTH + 2);
        @(negedge i_clk);
        check("t1_words", n_pop, DEPTH);
        check("t1_dones", n_done, 1);

        // Random data, random ready.
        fill_mem(1'b0);
        clear_model();
        rdy_mode = 1;
        pulse_start();
        wait_idle(8 * DEPTH);
        check("t2_words", n_pop, DEPTH);
        check("t2_dones", n_done, 1);

        // Sink stalled right after start: only two reads may be fetched.
        clear_model();
        rdy_mode = 2;
        @(negedge i_clk);
        pulse_start();
        repeat (20) @(negedge i_clk);
        check("stall_addr", bus.o_sram_addr, 2);
        check("stall_valid", bus.o_valid, 1);
        check("stall_data", bus.o_data, mem[0]);
        rdy_mode = 0;
        wait_idle(8 * DEPTH);
        check("t3_words", n_pop, DEPTH);
        check("t3_dones", n_done, 1);

        // Reset mid-frame after word 100, then a clean restart.
        clear_model();
        rdy_mode = 1;
        pulse_start();
        wait_pops(101, 8 * DEPTH);
        #2;
        mon_en = 1'b0;
        i_rst  = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge i_clk);
        i_rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
        repeat (5) @(negedge i_clk);
        check("midrst_no_done", n_done, 0);
        rdy_mode = 0;
        pulse_start();
        wait_idle(8 * DEPTH);
        check("t4_words", n_pop, DEPTH);
        check("t4_dones", n_done, 1);

        // Start pulsed again mid-frame is ignored.
        fill_mem(1'b0);
        clear_model();
        rdy_mode = 1;
        pulse_start();
        wait_pops(50, 8 * DEPTH);
        pulse_start();
        wait_idle(8 * DEPTH);
        check("t5_words", n_pop, DEPTH);
        check("t5_dones", n_done, 1);

`ifdef SCAN_REPEAT_EN
        // Continuous scan stopped during frame 2.
        clear_model();
        rdy_mode = 1;
        pulse_start();
        wait_pops(DEPTH + 10, 8 * DEPTH);
        @(negedge i_clk);
        i_stop = 1'b1;
        @(posedge i_clk);
        #1 i_stop = 1'b0;
        wait_idle(16 * DEPTH);
        check("t6_words", n_pop, 2 * DEPTH);
        check("t6_dones", n_done, 2);
`endif

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_scan_reader.md
# sram_scan_reader

Sequential read-side client for the team's single-port synchronous SRAM, which has a one-cycle registered read and reads whenever write is low. On a start pulse it walks addresses 0..DEPTH-1 and absorbs the SRAM's one-cycle read latency. It streams each word out on a valid/ready interface through a 2-entry output buffer. It sits between a framebuffer/palette SRAM and the pixel or scanout pipeline, and sustains one word per clock when the sink is always ready.

## Interface
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 8, SRAM word width.
- DEPTH, 256, words per frame; must satisfy DEPTH ≤ 2**ADDR_WIDTH and DEPTH ≥ 2.
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  begin a frame; sampled only in IDLE.
- i_stop  in  1  request end of continuous scanning (used only with SCAN_REPEAT_EN).
- o_busy  out  1  high in RUN and DRAIN.
- o_done  out  1  one-cycle pulse when the word from address DEPTH-1 is accepted.
- o_sram_addr  out  ADDR_WIDTH  registered read address to SRAM.
- o_sram_write  out  1  SRAM write enable; constant 0.
- i_sram_data  in  DATA_WIDTH  SRAM registered read data.
- o_data  out  DATA_WIDTH  head-of-buffer word.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  sink accepts o_data this cycle.

## Operation
- Reset values: o_busy 0, o_done 0, o_sram_addr 0, o_sram_write 0, o_data 0, o_valid 0. State IDLE, buffer empty, in-flight flag 0.
- FSM:
  - IDLE → RUN on i_start.
  - RUN → DRAIN after address DEPTH-1 is issued.
  - DRAIN → IDLE once the buffer is empty and no read is in flight.
- Issue rule: in RUN, a read is issued in a cycle when count + inflight − pop < 2.
  - count is buffer occupancy.
  - inflight is 1 if a read was issued the previous cycle.
  - pop is o_valid & i_ready.
- On issue, o_sram_addr advances to the next address at the clock edge; the current address is latched by the SRAM.
- When not issuing, o_sram_addr holds. The SRAM re-reads the same address, which is harmless because the in-flight flag is 0.
- Capture: when the in-flight flag is set, i_sram_data is written into the buffer at that edge. It is never captured otherwise.
- Ordering: words leave strictly in address order, with no drops or duplicates.
- The address counter is ADDR_WIDTH wide and is compared against DEPTH-1, not against 2**ADDR_WIDTH-1.
- i_start while busy is ignored. i_stop is ignored unless SCAN_REPEAT_EN is defined.
- Reset mid-frame: asynchronously returns to the reset values above. Partial frame data is discarded and no o_done is produced.

## Timing
- Start latency: with i_start sampled at edge E0, address 0 is issued in the E0→E1 cycle. Data is captured at E2, and o_valid is high from E2 onward (2 clocks).
- Throughput: 1 word/clock with i_ready held high. DEPTH words complete in DEPTH+2 clocks from start.
- Backpressure: while o_valid & !i_ready, o_data and o_valid hold stable. At most 2 words are buffered, and issue stalls with zero overflow.
- o_done is asserted in the cycle after the edge at which word DEPTH-1 is popped. o_busy falls at the same edge (non-repeat mode).
- Simultaneous push and pop on a full buffer is legal and leaves occupancy unchanged. Simultaneous push and pop on an empty buffer is impossible, because data must first enter the buffer.

## Configuration
- SCAN_REPEAT_EN:
  - Defined: after issuing DEPTH-1, the address wraps to 0 and RUN continues (no DRAIN). o_done pulses at the end of every frame and o_busy stays high.
  - A sampled i_stop is latched. The current frame then completes (addresses through DEPTH-1), followed by DRAIN and IDLE.
  - An i_stop latched in the same cycle that address DEPTH-1 is issued ends the scan at that frame.
- Undefined: single-frame operation only, i_stop has no effect, and the stop latch is absent.

## Test plan
- SRAM preloaded mem[a]=a, DEPTH=256, i_ready=1, start pulse → o_valid rises 2 clocks after start; o_data 0,1,…,255 on consecutive cycles; o_done a single pulse after 255; o_busy low after it.
- Same preload, i_ready toggling with a random 50% duty → the same 0..255 sequence with no gaps or repeats; o_data stable whenever o_valid&!i_ready; o_sram_write never 1.
- i_ready low for 20 cycles right after start → at most 2 words buffered; after release, output continues at 1, 2, ….
- i_rst asserted mid-frame after word 100 → all outputs return to reset values immediately; no o_done. A new start then begins again at 0.
- i_start pulsed again at word 50 → ignored; the sequence continues uninterrupted.
- SCAN_REPEAT_EN defined, i_stop pulsed during frame 2 at word 10 → frames 1 and 2 complete (o_done pulses twice); 512 words total; then IDLE.
